// File: rtl/pipe_rx_buffer_if.sv
// Valid/allow handshake plus show-ahead pop port between a pipeline tail and the rx buffer.
interface pipe_rx_buffer_if #(
  parameter int WIDTH = 4
);
  logic             validin;
  logic [WIDTH-1:0] datain;
  logic             allowout;
  logic             rd_en;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output validin, datain, rd_en,
    input  allowout, rd_valid, rd_data
  );

  modport slave (
    input  validin, datain, rd_en,
    output allowout, rd_valid, rd_data
  );
endinterface

// File: rtl/pipe_rx_buffer.sv
// Receive buffer for the valid/allow pipeline handshake: small FIFO with show-ahead read,
// incrementing-sequence checker and accepted-beat counter. All outputs come straight from flops.
module pipe_rx_buffer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_rx_buffer_if.slave        bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   seq_err,
  output logic [15:0]            beat_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             allow_q, allow_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             seen_q, seen_d;
  logic             seq_err_q, seq_err_d;
  logic [15:0]      beat_cnt_q, beat_cnt_d;

  logic acc_s;
  logic pop_s;

  // allow_q / rd_valid_q mirror count_q, so neither rd_en nor validin reaches allowout.
  assign acc_s = bus.validin && allow_q;
  assign pop_s = bus.rd_en && rd_valid_q;

  // Pointer and occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (acc_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({acc_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Registered view of the next head: a beat landing in the new head slot bypasses the memory
  always_comb begin
    allow_d    = (count_d != CNT_FULL);
    rd_valid_d = (count_d != CNT_ZERO);
    rd_data_d  = {WIDTH{1'b0}};
    if (!rd_valid_d) begin
      rd_data_d = {WIDTH{1'b0}};
    end else if (acc_s && (rd_ptr_d == wr_ptr_q)) begin
      rd_data_d = bus.datain;
    end else begin
      rd_data_d = mem_q[rd_ptr_d];
    end
  end

  // Sequence checker and beat counter; every accepted beat resyncs the expectation
  always_comb begin
    seen_d     = seen_q;
    exp_d      = exp_q;
    seq_err_d  = seq_err_q;
    beat_cnt_d = beat_cnt_q;
    if (acc_s) begin
      seen_d     = 1'b1;
      exp_d      = bus.datain + 1'b1;
      beat_cnt_d = beat_cnt_q + 16'd1;
      if (seen_q && (bus.datain != exp_q)) begin
        seq_err_d = 1'b1;
      end else begin
        seq_err_d = seq_err_q;
      end
    end else begin
      seen_d     = seen_q;
      exp_d      = exp_q;
      seq_err_d  = seq_err_q;
      beat_cnt_d = beat_cnt_q;
    end
  end

  // Control and status state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= CNT_ZERO;
      allow_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= {WIDTH{1'b0}};
      exp_q      <= {WIDTH{1'b0}};
      seen_q     <= 1'b0;
      seq_err_q  <= 1'b0;
      beat_cnt_q <= 16'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      allow_q    <= allow_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      exp_q      <= exp_d;
      seen_q     <= seen_d;
      seq_err_q  <= seq_err_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Storage is never cleared; reset only discards it via the pointers
  always_ff @(posedge clk) begin
    if (acc_s && !rst) begin
      mem_q[wr_ptr_q] <= bus.datain;
    end
  end

  assign bus.allowout = allow_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign count        = count_q;
  assign seq_err      = seq_err_q;
  assign beat_cnt     = beat_cnt_q;
endmodule

// File: tb/tb_pipe_rx_buffer.sv
// Directed bench for pipe_rx_buffer: queue-based reference model compared every cycle,
// plus literal expectations at the key points of each scenario.
module tb_pipe_rx_buffer;
  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   count;
  logic         seq_err;
  logic [15:0]  beat_cnt;

  pipe_rx_buffer_if #(.WIDTH(W)) bus ();

  pipe_rx_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .count    (count),
    .seq_err  (seq_err),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: a FIFO queue plus "last accepted value" bookkeeping
  int q[$];
  bit m_seen;
  bit m_err;
  int m_last;
  int m_beats;

  always @(posedge clk) begin
    bit acc, pop;
    if (rst) begin
      q.delete();
      m_seen  = 1'b0;
      m_err   = 1'b0;
      m_last  = 0;
      m_beats = 0;
    end else begin
      acc = bus.validin && (q.size() < D);
      pop = bus.rd_en && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (acc) begin
        if (m_seen && (int'(bus.datain) != ((m_last + 1) % (1 << W)))) m_err = 1'b1;
        m_seen  = 1'b1;
        m_last  = int'(bus.datain);
        q.push_back(int'(bus.datain));
        m_beats = (m_beats + 1) % 65536;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("allowout", bus.allowout, (q.size() != D));
      chk("rd_valid", bus.rd_valid, (q.size() != 0));
      chk("rd_data",  bus.rd_data,  (q.size() != 0) ? q[0] : 0);
      chk("count",    count,        q.size());
      chk("seq_err",  seq_err,      m_err);
      chk("beat_cnt", beat_cnt,     m_beats);
    end
  end

  task automatic step(input logic r, input logic v, input logic [W-1:0] d, input logic re);
    rst         = r;
    bus.validin = v;
    bus.datain  = d;
    bus.rd_en   = re;
    @(posedge clk);
    #1;
  endtask

  int stream_exp[4] = '{14, 15, 0, 1};
  int stream_in[4]  = '{14, 15, 0, 1};
  int seq_in[4]     = '{5, 6, 9, 10};
  int seq_err_exp[4] = '{0, 0, 1, 1};

  initial begin
    step(1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0);
    chk_en = 1'b1;
    chk("rst_allowout", bus.allowout, 1);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data",  bus.rd_data,  0);
    chk("rst_count",    count,        0);
    chk("rst_seq_err",  seq_err,      0);
    chk("rst_beat_cnt", beat_cnt,     0);

    // pop while empty is ignored
    step(1'b0, 1'b0, 4'd0, 1'b1);
    chk("empty_pop_count", count, 0);
    chk("empty_pop_valid", bus.rd_valid, 0);

    // fill 0..3, then 4 is held off
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, W'(i), 1'b0);
    chk("full_count",    count,        4);
    chk("full_allowout", bus.allowout, 0);
    chk("full_beats",    beat_cnt,     4);
    step(1'b0, 1'b1, 4'd4, 1'b0);
    chk("held_count", count,       4);
    chk("held_beats", beat_cnt,    4);
    chk("held_head",  bus.rd_data, 0);

    // full + validin + rd_en: pop only
    step(1'b0, 1'b1, 4'd4, 1'b1);
    chk("popfull_count", count,        3);
    chk("popfull_head",  bus.rd_data,  1);
    chk("popfull_allow", bus.allowout, 1);
    chk("popfull_beats", beat_cnt,     4);
    step(1'b0, 1'b1, 4'd4, 1'b0);
    chk("refill_count", count,    4);
    chk("refill_beats", beat_cnt, 5);
    chk("refill_err",   seq_err,  0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 1'b1);
    chk("drain_count", count, 0);

    // streaming across the data wrap
    step(1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, W'(stream_in[i]), 1'b1);
      chk("stream_count", count,       1);
      chk("stream_head",  bus.rd_data, stream_exp[i]);
    end
    step(1'b0, 1'b0, 4'd0, 1'b1);
    chk("stream_err",   seq_err,  0);
    chk("stream_beats", beat_cnt, 4);

    // sequence break 5,6,9,10
    step(1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, W'(seq_in[i]), 1'b1);
      chk("seq_err_step", seq_err, seq_err_exp[i]);
    end
    step(1'b0, 1'b0, 4'd0, 1'b1);

    // mid-operation reset with count=3, seq_err=1; coinciding beat and pop have no effect
    for (int i = 11; i < 14; i++) step(1'b0, 1'b1, W'(i), 1'b0);
    chk("prerst_count", count,   3);
    chk("prerst_err",   seq_err, 1);
    step(1'b1, 1'b1, 4'd2, 1'b1);
    chk("midrst_count", count,        0);
    chk("midrst_valid", bus.rd_valid, 0);
    chk("midrst_err",   seq_err,      0);
    chk("midrst_allow", bus.allowout, 1);
    chk("midrst_beats", beat_cnt,     0);
    step(1'b0, 1'b1, 4'd7, 1'b0);
    chk("post_rst_err",  seq_err,     0);
    chk("post_rst_head", bus.rd_data, 7);
    step(1'b0, 1'b1, 4'd3, 1'b0);
    chk("post_rst_break", seq_err, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
